// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000 bus sequencer: region and FSM encodings,
// region base nibbles for addr[23:20], and the address decode helper.
package m68k_bus_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_RAM, REG_EEPROM, REG_IO} region_t;
  typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, ERR} state_t;

  localparam logic [3:0] LOW_BASE    = 4'h0;
  localparam logic [3:0] RAM_BASE    = 4'h1;
  localparam logic [3:0] EEPROM_BASE = 4'hE;
  localparam logic [3:0] IO_BASE     = 4'hF;

  // The low megabyte is EEPROM while booting and RAM afterwards
  function automatic region_t decode_region(input logic boot, input logic [3:0] nib);
    if ((boot && nib == LOW_BASE) || nib == EEPROM_BASE) return REG_EEPROM;
    if ((!boot && nib == LOW_BASE) || nib == RAM_BASE)   return REG_RAM;
    if (nib == IO_BASE)                                  return REG_IO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for asynchronous CPU/peripheral strobes.
// Resets to 1 so active-low strobes read as idle out of reset.
module m68k_sync2 (
  input  logic clk50,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops
  always_ff @(posedge clk50) begin
    if (!reset_n) {q, meta} <= 2'b11;
    else          {q, meta} <= {meta, d};
  end

endmodule

// File: rtl/m68k_bus_sequencer.sv
// 68000 bus cycle sequencer: decodes addr[23:13] into a region, drives the
// chip selects, counts wait states and terminates with DTACK or BERR.
// Optional feature: define BERR_TIMEOUT_EN to end a WAIT that lasts TIMEOUT
// cycles with a bus error; without it WAIT holds until the device acks.
module m68k_bus_sequencer
  import m68k_bus_pkg::*;
#(
  parameter int unsigned RAM_WS    = 1,
  parameter int unsigned EEPROM_WS = 4,
  parameter int unsigned IO_WS     = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic         clk50,
  input  logic         reset_n,
  input  logic         as_n,
  input  logic         uds_n,
  input  logic         lds_n,
  input  logic         rw,
  input  logic [23:13] addr,
  input  logic         boot,
  input  logic         dtack_trig,
  output logic         dtack_n,
  output logic         berr_n,
  output logic         oe_n,
  output logic         ram_ce_n,
  output logic         eeprom_uds_n,
  output logic         eeprom_lds_n,
  output logic [3:0]   cs,
  output logic         busy
);

  localparam logic [CNT_W-1:0] RAM_WS_C    = CNT_W'(RAM_WS);
  localparam logic [CNT_W-1:0] EEPROM_WS_C = CNT_W'(EEPROM_WS);
  localparam logic [CNT_W-1:0] IO_WS_C     = CNT_W'(IO_WS);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  region_t          region;
  logic             rw_q;
  logic [1:0]       io_idx;
  logic [CNT_W-1:0] counter;
  logic [1:0]       vld_pipe;   // synchronizer contents are real once this fills
  logic             armed;      // as_s has been seen high since the last cycle start
  logic             as_s, dtack_s;
  logic             trusted, start, ack_ok, sel;

  m68k_sync2 u_sync_as    (.clk50(clk50), .reset_n(reset_n), .d(as_n),       .q(as_s));
  m68k_sync2 u_sync_dtack (.clk50(clk50), .reset_n(reset_n), .d(dtack_trig), .q(dtack_s));

  // Reset preloads the synchronizers with 1; ignore as_s until they have
  // been refilled so a strobe held low across reset never looks like a new edge.
  assign trusted = vld_pipe[1];
  assign start   = (state == IDLE) && trusted && armed && !as_s;

  logic unused_ok;
  assign unused_ok = ^{addr[19:15], TIMEOUT_C};

  // State, decode latch, wait counter and arming flag
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state    <= IDLE;
      region   <= REG_NONE;
      rw_q     <= 1'b0;
      io_idx   <= 2'd0;
      counter  <= '0;
      vld_pipe <= 2'b00;
      armed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (start) begin
        region <= decode_region(boot, addr[23:20]);
        rw_q   <= rw;
        io_idx <= addr[14:13];
        armed  <= 1'b0;
      end else if (trusted && as_s) begin
        armed  <= 1'b1;
      end
      // counter reads 1 in the first WAIT cycle, so ACK lands WS+2 after as_s falls
      unique case (state)
        IDLE:    counter <= '0;
        DECODE:  counter <= CNT_W'(1);
        WAIT:    if (counter != '1) counter <= counter + 1'b1;
        default: ;
      endcase
    end
  end

  // Region-specific termination condition while waiting
  always_comb begin
    ack_ok = 1'b0;
    unique case (region)
      REG_RAM:    ack_ok = (counter == RAM_WS_C);
      REG_EEPROM: ack_ok = (counter == EEPROM_WS_C);
      REG_IO:     ack_ok = (counter >= IO_WS_C) && dtack_s;
      default:    ack_ok = 1'b0;
    endcase
  end

  // Next-state: CPU releasing the strobe always wins over ack/timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = DECODE;
      DECODE: begin
        if (as_s)                    state_nxt = IDLE;
        else if (region == REG_NONE) state_nxt = ERR;
        else                         state_nxt = WAIT;
      end
      WAIT: begin
        if (as_s)        state_nxt = IDLE;
        else if (ack_ok) state_nxt = ACK;
`ifdef BERR_TIMEOUT_EN
        else if (counter == TIMEOUT_C) state_nxt = ERR;
`endif
      end
      ACK, ERR: if (as_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched region
  always_comb begin
    sel          = (state == DECODE) || (state == WAIT) || (state == ACK);
    busy         = (state != IDLE);
    dtack_n      = !(state == ACK);
    berr_n       = !(state == ERR);
    ram_ce_n     = !(sel && region == REG_RAM);
    oe_n         = !(sel && rw_q && (region == REG_RAM || region == REG_EEPROM));
    eeprom_uds_n = !(sel && region == REG_EEPROM && !uds_n);
    eeprom_lds_n = !(sel && region == REG_EEPROM && !lds_n);
    cs           = 4'hF;
    if (sel && region == REG_IO) cs[io_idx] = 1'b0;
  end

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Randomized bench for m68k_bus_sequencer with a cycle-timeline reference
// model derived from the region map, wait-state counts and strobe latency.
module tb_m68k_bus_sequencer;

  localparam int RAM_WS    = 1;
  localparam int EEPROM_WS = 4;
  localparam int IO_WS     = 2;
  localparam logic [9:0] IDLE_OUT = 10'b1111111110;
  localparam int NEVER = 1000000;

  logic         clk50 = 1'b0;
  logic         reset_n, as_n, uds_n, lds_n, rw, boot, dtack_trig;
  logic [23:13] addr;
  logic         dtack_n, berr_n, oe_n, ram_ce_n, eeprom_uds_n, eeprom_lds_n, busy;
  logic [3:0]   cs;
  logic [9:0]   obs;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk50 = ~clk50;

  m68k_bus_sequencer #(.RAM_WS(RAM_WS), .EEPROM_WS(EEPROM_WS), .IO_WS(IO_WS)) dut (
    .clk50(clk50), .reset_n(reset_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .boot(boot), .dtack_trig(dtack_trig),
    .dtack_n(dtack_n), .berr_n(berr_n), .oe_n(oe_n), .ram_ce_n(ram_ce_n),
    .eeprom_uds_n(eeprom_uds_n), .eeprom_lds_n(eeprom_lds_n), .cs(cs), .busy(busy)
  );

  assign obs = {dtack_n, berr_n, oe_n, ram_ce_n, eeprom_uds_n, eeprom_lds_n, cs, busy};

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 EEPROM, 3 IO
  function automatic int ref_region(input logic b, input logic [23:0] a);
    logic [3:0] n;
    n = a[23:20];
    if ((b && n == 4'h0) || n == 4'hE) return 2;
    if ((!b && n == 4'h0) || n == 4'h1) return 1;
    if (n == 4'hF) return 3;
    return 0;
  endfunction

  // Edges are counted from the drive of as_n low: as_s falls at edge 2,
  // DECODE at 3, WAIT from 4; release at edge rel makes as_s high at rel+2
  // and the FSM idle at rel+3.
  task automatic run_txn(input logic [23:0] a, input logic b, input logic r_w,
                         input logic u, input logic l, input int trig_at, input bit abort);
    int rk, ack_e, err_e, rel, exit_e;
    logic sel, ack, err, bsy;
    logic [3:0] cs_e;
    logic [9:0] exp;
    rk    = ref_region(b, a);
    ack_e = NEVER;
    err_e = NEVER;
    case (rk)
      1: ack_e = RAM_WS + 4;
      2: ack_e = EEPROM_WS + 4;
      3: ack_e = (IO_WS + 4 > trig_at + 3) ? IO_WS + 4 : trig_at + 3;
      default: err_e = 4;
    endcase
    if (abort && rk != 0) rel = 2 + int'($urandom_range(0, ack_e - 5));
    else                  rel = ((rk == 0) ? err_e : ack_e) + int'($urandom_range(0, 3));
    exit_e = rel + 3;
    @(posedge clk50); #1;
    addr = a[23:13]; boot = b; rw = r_w; uds_n = u; lds_n = l; as_n = 1'b0;
    if (trig_at == 0) dtack_trig = 1'b1;
    for (int k = 1; k <= exit_e + 1; k++) begin
      @(posedge clk50); #1;
      if (k == trig_at && k < rel) dtack_trig = 1'b1;
      if (k == rel) begin as_n = 1'b1; dtack_trig = 1'b0; end
      @(negedge clk50);
      sel  = (rk != 0) && k >= 3 && k < exit_e;
      ack  = (rk != 0) && k >= ack_e && k < exit_e;
      err  = (rk == 0) && k >= err_e && k < exit_e;
      bsy  = k >= 3 && k < exit_e;
      cs_e = (sel && rk == 3) ? ~(4'b0001 << a[14:13]) : 4'hF;
      exp  = {!ack, !err, !(sel && r_w && (rk == 1 || rk == 2)), !(sel && rk == 1),
              !(sel && rk == 2 && !u), !(sel && rk == 2 && !l), cs_e, bsy};
      chk($sformatf("a%06h k%0d", a, k), obs, exp);
      chk($sformatf("excl a%06h k%0d", a, k), {9'b0, dtack_n | berr_n}, 10'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    logic [3:0]  nib;
    reset_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    boot = 1'b0; addr = '0; dtack_trig = 1'b0;
    repeat (3) @(posedge clk50);
    @(negedge clk50) chk("reset", obs, IDLE_OUT);
    @(posedge clk50); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk50);
    @(negedge clk50) chk("post_reset", obs, IDLE_OUT);

    run_txn(24'h100000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_txn(24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_txn(24'hF04000, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    run_txn(24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_txn(24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_txn(24'hE12000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);

    // Reset in the middle of an EEPROM wait with the strobe held low
    a = 24'hE00000;
    @(posedge clk50); #1;
    addr = a[23:13]; boot = 1'b0; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    repeat (5) @(posedge clk50);
    @(negedge clk50) chk("pre_rst_busy", {9'b0, busy}, 10'd1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk50);
    @(negedge clk50) chk("in_rst", obs, IDLE_OUT);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk50) chk($sformatf("rst_hold%0d", i), obs, IDLE_OUT);
    end
    @(posedge clk50); #1 as_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk50) chk($sformatf("rst_rel%0d", i), obs, IDLE_OUT);
    end
    run_txn(24'h1FE000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0: nib = 4'h0;
        1: nib = 4'h1;
        2: nib = 4'hE;
        3: nib = 4'hF;
        default: nib = 4'($urandom);
      endcase
      a = {nib, 20'($urandom)};
      run_txn(a, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 10)), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk50);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
